// File: rtl/nobl_multichan_fifo.sv
// Multi-channel FIFO controller over one ZBT/NoBL SRAM: each channel owns an equal circular
// region; one SRAM op per cycle, write/read alternation, round-robin reads, per-channel flush.
module nobl_multichan_fifo #(
  parameter int WIDTH     = 18,
  parameter int RAM_DEPTH = 19,
  parameter int CHAN_BITS = 2
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [WIDTH-1:0]                                    RAM_D_pi,
  output logic [WIDTH-1:0]                                    RAM_D_po,
  output logic                                                RAM_D_poe,
  output logic [RAM_DEPTH-1:0]                                RAM_A,
  output logic                                                RAM_WEn,
  output logic                                                RAM_CENn,
  output logic                                                RAM_LDn,
  output logic                                                RAM_OEn,
  output logic                                                RAM_CE1n,
  input  logic [WIDTH-1:0]                                    wr_data,
  input  logic [CHAN_BITS-1:0]                                wr_chan,
  input  logic                                                wr_valid,
  output logic                                                wr_ready,
  input  logic [2**CHAN_BITS-1:0]                             rd_strobe,
  output logic [WIDTH-1:0]                                    rd_data,
  output logic [CHAN_BITS-1:0]                                rd_chan,
  output logic                                                rd_valid,
  input  logic [2**CHAN_BITS-1:0]                             flush,
  output logic [2**CHAN_BITS-1:0]                             data_avail,
  output logic [(2**CHAN_BITS)*(RAM_DEPTH-CHAN_BITS+1)-1:0]   occupancy
);
  localparam int NUM_CHAN = 2**CHAN_BITS;
  localparam int OFF_BITS = RAM_DEPTH - CHAN_BITS;
  localparam int PTR_BITS = OFF_BITS + 1;
  localparam logic [PTR_BITS-1:0] REGION = {1'b1, {OFF_BITS{1'b0}}};

  logic [PTR_BITS-1:0]  r_wptr  [NUM_CHAN];
  logic [PTR_BITS-1:0]  r_rptr  [NUM_CHAN];
  logic [PTR_BITS-1:0]  r_cwptr [NUM_CHAN];
  logic [PTR_BITS-1:0]  w_occ   [NUM_CHAN];
  logic [NUM_CHAN-1:0]  w_full;
  logic [NUM_CHAN-1:0]  w_rd_elig;
  logic                 r_run;
  logic                 r_last_wr;
  logic [CHAN_BITS-1:0] r_last_rd;
  logic [CHAN_BITS-1:0] w_rd_sel;
  logic [CHAN_BITS-1:0] w_rr_idx;
  logic                 w_w;
  logic                 w_r;
  logic                 w_gnt_wr;
  logic                 w_gnt_rd;
  logic                 w_found;

  // Write pipeline: stage 0 = address cycle, stage 2 = late-write data cycle.
  logic [2:0]           r_wv;
  logic [1:0]           r_wc;
  logic [CHAN_BITS-1:0] r_wch [2];
  logic [WIDTH-1:0]     r_wd  [3];
  logic [2:0]           r_rv;
  logic [CHAN_BITS-1:0] r_rch [3];

  always_comb begin
    for (int c = 0; c < NUM_CHAN; c++) begin
      w_occ[c]      = r_wptr[c] - r_rptr[c];
      w_full[c]     = (w_occ[c] == REGION);
      data_avail[c] = (r_cwptr[c] != r_rptr[c]);
    end
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_occ
    assign occupancy[c*PTR_BITS +: PTR_BITS] = w_occ[c];
  end

  always_comb begin
    w_rd_elig = data_avail & rd_strobe & ~flush;
    w_w       = r_run & wr_valid & ~w_full[wr_chan] & ~flush[wr_chan];
    w_r       = r_run & (|w_rd_elig);
    w_gnt_wr  = w_w & (~w_r | ~r_last_wr);
    w_gnt_rd  = w_r & (~w_w | r_last_wr);
    w_rd_sel  = r_last_rd;
    w_rr_idx  = r_last_rd;
    w_found   = 1'b0;
    for (int i = 1; i <= NUM_CHAN; i++) begin
      w_rr_idx = r_last_rd + CHAN_BITS'(i);
      if (!w_found && w_rd_elig[w_rr_idx]) begin
        w_rd_sel = w_rr_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign wr_ready = w_gnt_wr;

  // Flush outranks every pointer update on its channel, including a commit landing this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_cwptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (flush[c]) begin
          r_wptr[c]  <= '0;
          r_rptr[c]  <= '0;
          r_cwptr[c] <= '0;
        end else begin
          if (w_gnt_wr && wr_chan == CHAN_BITS'(c))
            r_wptr[c] <= r_wptr[c] + PTR_BITS'(1);
          if (w_gnt_rd && w_rd_sel == CHAN_BITS'(c))
            r_rptr[c] <= r_rptr[c] + PTR_BITS'(1);
          if (r_wv[1] && r_wc[1] && r_wch[1] == CHAN_BITS'(c))
            r_cwptr[c] <= r_cwptr[c] + PTR_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_last_wr <= 1'b0;
      r_last_rd <= '1;
      RAM_A     <= '0;
      RAM_WEn   <= 1'b1;
      RAM_CENn  <= 1'b1;
      RAM_LDn   <= 1'b1;
      r_wv      <= '0;
      r_wc      <= '0;
      r_rv      <= '0;
      for (int s = 0; s < 3; s++) begin
        r_wd[s]  <= '0;
        r_rch[s] <= '0;
      end
      for (int s = 0; s < 2; s++) r_wch[s] <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_chan   <= '0;
    end else begin
      r_run    <= 1'b1;
      RAM_WEn  <= 1'b1;
      RAM_CENn <= 1'b1;
      RAM_LDn  <= 1'b1;
      if (w_gnt_wr) begin
        RAM_A     <= {wr_chan, r_wptr[wr_chan][OFF_BITS-1:0]};
        RAM_WEn   <= 1'b0;
        RAM_CENn  <= 1'b0;
        RAM_LDn   <= 1'b0;
        r_last_wr <= 1'b1;
      end else if (w_gnt_rd) begin
        RAM_A     <= {w_rd_sel, r_rptr[w_rd_sel][OFF_BITS-1:0]};
        RAM_CENn  <= 1'b0;
        RAM_LDn   <= 1'b0;
        r_last_wr <= 1'b0;
        r_last_rd <= w_rd_sel;
      end
      // Flushed writes still reach the SRAM but never bump the committed pointer.
      r_wv     <= {r_wv[1:0], w_gnt_wr};
      r_wc     <= {r_wc[0] & ~flush[r_wch[0]], w_gnt_wr};
      r_wch[0] <= wr_chan;
      r_wch[1] <= r_wch[0];
      r_wd[0]  <= wr_data;
      r_wd[1]  <= r_wd[0];
      r_wd[2]  <= r_wd[1];
      r_rv     <= {r_rv[1] & ~flush[r_rch[1]], r_rv[0] & ~flush[r_rch[0]], w_gnt_rd};
      r_rch[0] <= w_rd_sel;
      r_rch[1] <= r_rch[0];
      r_rch[2] <= r_rch[1];
      rd_valid <= r_rv[2] & ~flush[r_rch[2]];
      if (r_rv[2]) begin
        rd_data <= RAM_D_pi;
        rd_chan <= r_rch[2];
      end
    end
  end

  assign RAM_D_po  = r_wd[2];
  assign RAM_D_poe = r_wv[2];
  assign RAM_OEn   = ~r_run;
  assign RAM_CE1n  = ~r_run;

endmodule

// File: tb/tb_nobl_multichan_fifo.sv
// Directed bench for nobl_multichan_fifo with a small behavioural ZBT SRAM model
// (address cycle k, write data at k+2, read data at k+2).
module tb_nobl_multichan_fifo;
  localparam int W  = 18;
  localparam int RD = 6;
  localparam int CB = 2;
  localparam int NC = 4;
  localparam int PB = RD - CB + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    RAM_D_pi = '0;
  logic [W-1:0]    RAM_D_po;
  logic            RAM_D_poe;
  logic [RD-1:0]   RAM_A;
  logic            RAM_WEn, RAM_CENn, RAM_LDn, RAM_OEn, RAM_CE1n;
  logic [W-1:0]    wr_data;
  logic [CB-1:0]   wr_chan;
  logic            wr_valid;
  logic            wr_ready;
  logic [NC-1:0]   rd_strobe;
  logic [W-1:0]    rd_data;
  logic [CB-1:0]   rd_chan;
  logic            rd_valid;
  logic [NC-1:0]   flush;
  logic [NC-1:0]   data_avail;
  logic [NC*PB-1:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;

  nobl_multichan_fifo #(.WIDTH(W), .RAM_DEPTH(RD), .CHAN_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .RAM_D_pi(RAM_D_pi), .RAM_D_po(RAM_D_po), .RAM_D_poe(RAM_D_poe),
    .RAM_A(RAM_A), .RAM_WEn(RAM_WEn), .RAM_CENn(RAM_CENn), .RAM_LDn(RAM_LDn), .RAM_OEn(RAM_OEn),
    .RAM_CE1n(RAM_CE1n), .wr_data(wr_data), .wr_chan(wr_chan), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_strobe(rd_strobe), .rd_data(rd_data), .rd_chan(rd_chan),
    .rd_valid(rd_valid), .flush(flush), .data_avail(data_avail), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // SRAM model
  logic [W-1:0]  mem [2**RD];
  logic          wa_v1 = 1'b0, wa_v2 = 1'b0, ra_v = 1'b0;
  logic [RD-1:0] wa1 = '0, wa2 = '0, ra1 = '0;
  initial for (int i = 0; i < 2**RD; i++) mem[i] = '0;
  always @(posedge clk) begin
    wa_v1 <= !RAM_CENn && !RAM_WEn;
    wa1   <= RAM_A;
    wa_v2 <= wa_v1;
    wa2   <= wa1;
    if (wa_v2 && RAM_D_poe) mem[wa2] <= RAM_D_po;
    ra_v  <= !RAM_CENn && RAM_WEn;
    ra1   <= RAM_A;
    RAM_D_pi <= ra_v ? mem[ra1] : '0;
  end

  logic [CB-1:0] q_ch [$];
  logic [W-1:0]  q_d  [$];
  always @(negedge clk) if (rd_valid) begin
    q_ch.push_back(rd_chan);
    q_d.push_back(rd_data);
  end

  // ch3 write-address monitor for the wrap test
  logic mon_en = 1'b0;
  logic mon_have = 1'b0;
  logic [RD-CB-1:0] mon_prev = '0;
  int mon_wraps = 0;
  int mon_seq_err = 0;
  always @(negedge clk) if (mon_en && !RAM_CENn && !RAM_WEn && RAM_A[RD-1:RD-CB] == 2'd3) begin
    if (mon_have && RAM_A[RD-CB-1:0] != mon_prev + 1'b1) mon_seq_err++;
    if (mon_have && RAM_A[RD-CB-1:0] == '0) mon_wraps++;
    mon_prev = RAM_A[RD-CB-1:0];
    mon_have = 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PB-1:0] occ(input int c);
    return occupancy[c*PB +: PB];
  endfunction

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_write(input int ch, input int d);
    int tries;
    tries = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_chan  = CB'(ch);
    wr_data  = W'(d);
    #1;
    while (!wr_ready && tries < 60) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!wr_ready) check_val("wr_timeout", 0, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_reads(input int n, input int budget);
    for (int t = 0; t < budget && q_d.size() < n; t++) @(negedge clk);
    if (q_d.size() < n) check_val("rd_timeout", q_d.size(), n);
  endtask

  task automatic pop_chk(input string tag, input int ch, input int d);
    if (q_d.size() == 0) check_val({tag, "_missing"}, 0, 1);
    else begin
      check_val({tag, "_ch"}, q_ch.pop_front(), ch);
      check_val({tag, "_d"}, q_d.pop_front(), d);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_rd_valid"}, rd_valid, 0);
    check_val({tag, "_rd_data"}, rd_data, 0);
    check_val({tag, "_rd_chan"}, rd_chan, 0);
    check_val({tag, "_wr_ready"}, wr_ready, 0);
    check_val({tag, "_poe"}, RAM_D_poe, 0);
    check_val({tag, "_ctl"}, {RAM_CENn, RAM_WEn, RAM_LDn, RAM_OEn, RAM_CE1n}, 5'b11111);
    check_val({tag, "_addr"}, RAM_A, 0);
    check_val({tag, "_avail"}, data_avail, 0);
    check_val({tag, "_occ"}, occupancy, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b1; wr_chan = '0; wr_data = '0;
    rd_strobe = '0; flush = '0;

    // reset state
    wait_cyc(3);
    #1;
    check_reset_outs("rst");
    wr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_oen_ce1n", {RAM_OEn, RAM_CE1n}, 2'b00);
    wait_cyc(1);

    // round-robin: each channel 4 words, all strobes high
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 4; i++) do_write(c, 'h300 + c*16 + i);
    wait_cyc(5);
    check_val("rr_avail", data_avail, 4'hF);
    rd_strobe = 4'hF;
    wait_reads(16, 80);
    rd_strobe = '0;
    for (int j = 0; j < 16; j++) pop_chk("rr", j % 4, 'h300 + (j % 4)*16 + j/4);

    // ch1: 8 words, latency and ordering
    for (int i = 0; i < 8; i++) do_write(1, 'h100 + i);
    wait_cyc(5);
    check_val("c1_occ8", occ(1), 8);
    check_val("c1_avail", data_avail, 4'b0010);
    @(negedge clk);
    rd_strobe = 4'b0010;
    wait_cyc(3);
    check_val("c1_lat3_valid", rd_valid, 0);
    @(negedge clk);
    check_val("c1_lat4_valid", rd_valid, 1);
    check_val("c1_lat4_data", rd_data, 'h100);
    wait_reads(8, 40);
    rd_strobe = '0;
    for (int i = 0; i < 8; i++) pop_chk("c1", 1, 'h100 + i);
    wait_cyc(2);
    check_val("c1_occ0", occ(1), 0);
    check_val("c1_avail0", data_avail, 0);

    // ch2 full
    for (int i = 0; i < 16; i++) do_write(2, 'h200 + i);
    wait_cyc(5);
    check_val("c2_occ_full", occ(2), 16);
    @(negedge clk);
    wr_valid = 1'b1; wr_chan = 2'd2; #1;
    check_val("c2_full_rdy", wr_ready, 0);
    wr_chan = 2'd0; #1;
    check_val("c0_rdy_while_c2_full", wr_ready, 1);
    wr_valid = 1'b0;
    @(negedge clk);
    rd_strobe = 4'b0100;
    @(posedge clk); #1;
    rd_strobe = '0;
    @(negedge clk);
    wr_valid = 1'b1; wr_chan = 2'd2; #1;
    check_val("c2_rdy_after_read", wr_ready, 1);
    wr_valid = 1'b0;
    rd_strobe = 4'b0100;
    wait_reads(16, 60);
    rd_strobe = '0;
    for (int i = 0; i < 16; i++) pop_chk("c2", 2, 'h200 + i);

    // W/R alternation: ch0 reads pending, continuous ch1 writes
    begin
      int wi;
      wi = 0;
      for (int i = 0; i < 4; i++) do_write(0, 'h400 + i);
      wait_cyc(6);
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        if (i > 0) begin
          check_val("alt_cen", RAM_CENn, 0);
          check_val("alt_wen", RAM_WEn, i % 2);
        end
        if (i < 8) begin
          wr_valid = 1'b1; wr_chan = 2'd1; wr_data = W'('h500 + wi); rd_strobe = 4'b0001;
          #1;
          check_val("alt_rdy", wr_ready, (i % 2));
          if (wr_ready) wi++;
        end
      end
      wr_valid = 1'b0; rd_strobe = '0;
      check_val("alt_wcount", wi, 4);
      wait_reads(4, 20);
      for (int i = 0; i < 4; i++) pop_chk("alt_c0", 0, 'h400 + i);
      rd_strobe = 4'b0010;
      wait_reads(4, 30);
      rd_strobe = '0;
      for (int i = 0; i < 4; i++) pop_chk("alt_c1", 1, 'h500 + i);
    end

    // wrap: ch3 streams 48 words starting at offset 4 -> three wraps
    mon_en = 1'b1;
    rd_strobe = 4'b1000;
    fork
      for (int i = 0; i < 48; i++) do_write(3, 'h1000 + i);
      wait_reads(48, 600);
    join
    rd_strobe = '0;
    mon_en = 1'b0;
    for (int i = 0; i < 48; i++) pop_chk("wrap", 3, 'h1000 + i);
    check_val("wrap_count", mon_wraps, 3);
    check_val("wrap_seq", mon_seq_err, 0);
    wait_cyc(2);
    check_val("wrap_occ0", occ(3), 0);

    // flush ch1 with two reads in flight
    for (int i = 0; i < 4; i++) do_write(1, 'h600 + i);
    wait_cyc(6);
    @(negedge clk);
    rd_strobe = 4'b0010;
    wait_cyc(2);
    rd_strobe = '0; flush = 4'b0010;
    @(negedge clk);
    flush = '0;
    wait_cyc(8);
    check_val("fl_no_rd", q_d.size(), 0);
    check_val("fl_occ", occ(1), 0);
    check_val("fl_avail", data_avail, 0);
    do_write(1, 'h6F0);
    flush = 4'b0010;
    @(posedge clk); #1;
    flush = '0;
    wait_cyc(6);
    check_val("fl_wr_occ", occ(1), 0);
    check_val("fl_wr_avail", data_avail, 0);
    do_write(1, 'h610);
    do_write(1, 'h611);
    wait_cyc(5);
    rd_strobe = 4'b0010;
    wait_reads(2, 20);
    rd_strobe = '0;
    pop_chk("fl_after0", 1, 'h610);
    pop_chk("fl_after1", 1, 'h611);

    // reset mid-burst
    for (int i = 0; i < 4; i++) do_write(0, 'h700 + i);
    wait_cyc(6);
    @(negedge clk);
    rd_strobe = 4'b0001;
    wait_cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(8);
    rd_strobe = '0;
    check_val("mid_rst_no_rd", q_d.size(), 0);
    check_val("mid_rst_avail", data_avail, 0);
    check_val("mid_rst_occ", occupancy, 0);
    check_val("mid_rst_oen", {RAM_OEn, RAM_CE1n}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
